tmds_encoder_dvi: RTL and testbench

- Single-channel DVI 1.0 TMDS encoder.
- Sits directly downstream of the display timing generator and pixel source, in the pixel clock domain.
- Takes 8-bit colour data, the 2-bit control word and display enable, and produces a DC-balanced, transition-minimised 10-bit symbol for the serialiser.
- Three instances form a DVI transmitter: blue carries {vs, hs} as ctrl, green and red carry 2'b00.

---
 rtl/tmds_encoder_dvi.sv | 84 ++++++++
 tb/tb_tmds_encoder_dvi.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_dvi.sv
// Single-channel DVI TMDS encoder: 8b pixel / 2b control in, 10b symbol out.
// Two register stages: transition minimisation (q_m), then DC balance (o_tmds, cnt).
module tmds_encoder_dvi (
  input  logic       i_pixclk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output logic [9:0] o_tmds
);

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        q_m_next;
  logic [8:0]        q_m;
  logic              de_q;
  logic [1:0]        ctrl_q;
  logic signed [4:0] cnt;
  logic [3:0]        n1_qm;
  logic signed [4:0] diff;
  logic signed [4:0] cnt_next;
  logic [9:0]        sym_next;

  always_comb begin
    n1_data = 4'd0;
    for (int i = 0; i < 8; i++) n1_data = n1_data + {3'b000, i_data[i]};
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !i_data[0]);
    q_m_next = 9'd0;
    q_m_next[0] = i_data[0];
    for (int i = 1; i < 8; i++)
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ i_data[i]) : (q_m_next[i-1] ^ i_data[i]);
    q_m_next[8] = ~use_xnor;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      q_m    <= 9'd0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m    <= q_m_next;
      de_q   <= i_de;
      ctrl_q <= i_ctrl;
    end
  end

  // Disparity math is done modulo 32: the true result always lies in -8..+8,
  // so the low five bits match a wider signed computation truncated to 5 bits.
  always_comb begin
    n1_qm = 4'd0;
    for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, q_m[i]};
    diff     = $signed({n1_qm, 1'b0}) - 5'sd8;
    sym_next = 10'h354;
    cnt_next = 5'sd0;
    if (!de_q) begin
      case (ctrl_q)
        2'b00:   sym_next = 10'b1101010100;
        2'b01:   sym_next = 10'b0010101011;
        2'b10:   sym_next = 10'b0101010100;
        default: sym_next = 10'b1010101011;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      sym_next = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      sym_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt - diff + (q_m[8] ? 5'sd2 : 5'sd0);
    end else begin
      sym_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      o_tmds <= 10'b1101010100;
      cnt    <= 5'sd0;
    end else begin
      o_tmds <= sym_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed scenarios plus random
// traffic against a behavioural encoder model and a symbol decoder.
module tb_tmds_encoder_dvi;

  logic       i_pixclk = 1'b0;
  logic       i_rst    = 1'b1;
  logic [7:0] i_data   = 8'h00;
  logic [1:0] i_ctrl   = 2'b00;
  logic       i_de     = 1'b0;
  logic [9:0] o_tmds;

  int errors = 0;
  int checks = 0;

  // model: inputs captured at the previous edge, running disparity, expected output
  logic       m_de;
  logic [1:0] m_ctrl;
  logic [7:0] m_data;
  int         m_cnt;
  logic [9:0] m_out;

  tmds_encoder_dvi dut (
    .i_pixclk(i_pixclk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_ctrl  (i_ctrl),
    .i_de    (i_de),
    .o_tmds  (o_tmds)
  );

  always #5 i_pixclk = ~i_pixclk;

  function automatic int dut_cnt();
    return int'($signed(dut.cnt));
  endfunction

  // One rising edge; the model encodes the symbol captured at the previous edge.
  task automatic tick();
    logic [8:0] qm;
    int n1d, n1, n0;
    bit xn;
    @(posedge i_pixclk);
    if (i_rst) begin
      m_out = 10'h354; m_cnt = 0;
      m_de = 1'b0; m_ctrl = 2'b00; m_data = 8'h00;
    end else begin
      if (!m_de) begin
        case (m_ctrl)
          2'd0: m_out = 10'h354;
          2'd1: m_out = 10'h0AB;
          2'd2: m_out = 10'h154;
          default: m_out = 10'h2AB;
        endcase
        m_cnt = 0;
      end else begin
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += m_data[i];
        xn = (n1d > 4) || (n1d == 4 && m_data[0] == 1'b0);
        qm[0] = m_data[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ m_data[i]) : (qm[i-1] ^ m_data[i]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += qm[i];
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
          m_out = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
          m_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
          m_out = {1'b1, qm[8], ~qm[7:0]};
          m_cnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
          m_out = {1'b0, qm[8], qm[7:0]};
          m_cnt += (n1 - n0) - 2 * int'(!qm[8]);
        end
      end
      m_de = i_de; m_ctrl = i_ctrl; m_data = i_data;
    end
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_de = 1'b0; i_ctrl = 2'b00; i_data = 8'h00;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    do_reset();
    checks++;
    if (o_tmds !== 10'h354) begin errors++; $display("FAIL reset_out: got %h expected 354", o_tmds); end
    checks++;
    if (dut_cnt() !== 0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut_cnt()); end
    for (int k = 0; k < 6; k++) begin
      i_ctrl = (k < 4) ? k[1:0] : 2'b11;
      i_data = 8'hA5;
      tick();
      if (k >= 1) begin
        checks++;
        if (o_tmds !== tok[(k - 1 > 3) ? 3 : k - 1]) begin
          errors++; $display("FAIL ctrl_token[%0d]: got %h expected %h", k, o_tmds, tok[(k - 1 > 3) ? 3 : k - 1]);
        end
      end
    end
  endtask

  task automatic test_zeros();
    logic [9:0] exp_o [4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    int exp_c [4] = '{-8, 2, -6, 4};
    do_reset();
    i_de = 1'b1; i_data = 8'h00;
    tick();
    checks++;
    if (o_tmds !== 10'h354) begin errors++; $display("FAIL zeros_fill: got %h expected 354", o_tmds); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_tmds !== exp_o[k]) begin errors++; $display("FAIL zeros_out[%0d]: got %h expected %h", k, o_tmds, exp_o[k]); end
      checks++;
      if (dut_cnt() !== exp_c[k]) begin errors++; $display("FAIL zeros_cnt[%0d]: got %0d expected %0d", k, dut_cnt(), exp_c[k]); end
    end
  endtask

  task automatic test_ones();
    do_reset();
    i_de = 1'b1; i_data = 8'hFF;
    tick();
    i_de = 1'b0; i_ctrl = 2'b00;
    tick();
    checks++;
    if (o_tmds !== 10'h200) begin errors++; $display("FAIL ones_out: got %h expected 200", o_tmds); end
    checks++;
    if (dut_cnt() !== -8) begin errors++; $display("FAIL ones_cnt: got %0d expected -8", dut_cnt()); end
  endtask

  task automatic test_blank_resets_cnt();
    do_reset();
    i_de = 1'b1; i_data = 8'h00;
    tick();
    i_de = 1'b0; i_ctrl = 2'b00; i_data = 8'hFF;
    tick();
    checks++;
    if (o_tmds !== 10'h100) begin errors++; $display("FAIL blank_v0: got %h expected 100", o_tmds); end
    i_de = 1'b1; i_data = 8'h00; i_ctrl = 2'b11;
    tick();
    checks++;
    if (o_tmds !== 10'h354 || dut_cnt() !== 0) begin
      errors++; $display("FAIL blank_ctrl: got %h cnt %0d expected 354 cnt 0", o_tmds, dut_cnt());
    end
    tick();
    checks++;
    if (o_tmds !== 10'h100) begin errors++; $display("FAIL blank_v1: got %h expected 100", o_tmds); end
  endtask

  task automatic test_latency_reset();
    logic [7:0] sent [$];
    logic [7:0] d;
    do_reset();
    i_de = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d = 8'h11 * k[7:0] + 8'h03;
      i_data = d;
      sent.push_back(d);
      tick();
      if (k >= 1) begin
        checks++;
        if (o_tmds !== m_out) begin errors++; $display("FAIL latency[%0d]: got %h expected %h", k, o_tmds, m_out); end
      end
    end
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_tmds !== 10'h354) begin errors++; $display("FAIL midrst_out: got %h expected 354", o_tmds); end
    i_rst = 1'b0; i_de = 1'b1; i_data = 8'h00;
    tick();
    checks++;
    if (o_tmds !== 10'h354) begin errors++; $display("FAIL post_rst_flush: got %h expected 354", o_tmds); end
    i_data = 8'h5A;
    tick();
    checks++;
    if (o_tmds !== 10'h100) begin errors++; $display("FAIL post_rst_first: got %h expected 100", o_tmds); end
  endtask

  task automatic test_random();
    logic [10:0] hist [$];
    logic [10:0] h;
    logic [7:0]  low, dec;
    logic [1:0]  dctl;
    do_reset();
    for (int k = 0; k < 20000; k++) begin
      i_de   = ($urandom_range(0, 7) != 0);
      i_data = 8'($urandom);
      i_ctrl = 2'($urandom);
      hist.push_back({i_de, i_ctrl, i_data});
      tick();
      checks++;
      if (o_tmds !== m_out) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", k, o_tmds, m_out); end
      checks++;
      if (dut_cnt() !== m_cnt || (m_cnt % 2) != 0 || m_cnt > 8 || m_cnt < -8) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", k, dut_cnt(), m_cnt);
      end
      if (hist.size() == 2) begin
        h = hist.pop_front();
        checks++;
        if (h[10]) begin
          low = o_tmds[9] ? ~o_tmds[7:0] : o_tmds[7:0];
          dec[0] = low[0];
          for (int i = 1; i < 8; i++) dec[i] = o_tmds[8] ? (low[i] ^ low[i-1]) : ~(low[i] ^ low[i-1]);
          if (dec !== h[7:0]) begin errors++; $display("FAIL rand_decode[%0d]: got %h expected %h", k, dec, h[7:0]); end
        end else begin
          case (o_tmds)
            10'h354: dctl = 2'd0;
            10'h0AB: dctl = 2'd1;
            10'h154: dctl = 2'd2;
            10'h2AB: dctl = 2'd3;
            default: dctl = 2'bxx;
          endcase
          if (dctl !== h[9:8]) begin errors++; $display("FAIL rand_ctrl_decode[%0d]: got %h expected %h", k, o_tmds, h[9:8]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_blank_resets_cnt();
    test_latency_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
